alu_writeback_regfile: RTL and testbench

- Consumer end of the ALU result path: accepts {rd, result, isFalse} beats from the ALU, stages them one cycle, and commits them into a 32x32 general-purpose register file.
- Supplies the rs1/rs2 operand values back to the ALU through two combinational read ports, with bypass from the staged write.
- Suppresses writes that the ALU has flagged as erroneous (overflow or illegal function) and records the first such error for the exception logic.

---
 rtl/alu_writeback_regfile.sv | 119 +++++++++++
 tb/tb_alu_writeback_regfile.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_writeback_regfile.sv
// ALU writeback stage: stages one result beat per cycle, commits it to a 2**ADDR_W x DATA_W
// register file, bypasses the staged write to two read ports, and records erroneous beats.
module alu_writeback_regfile #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned ERR_CNT_W   = 8,
  parameter bit          HALT_ON_ERR = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wb_valid,
  output logic                 wb_ready,
  input  logic                 wb_reg_write,
  input  logic [ADDR_W-1:0]    wb_rd,
  input  logic [DATA_W-1:0]    wb_result,
  input  logic                 wb_is_false,
  input  logic [ADDR_W-1:0]    rs_addr,
  input  logic [ADDR_W-1:0]    rt_addr,
  output logic [DATA_W-1:0]    rs_data,
  output logic [DATA_W-1:0]    rt_data,
  input  logic                 err_clear,
  output logic                 err_flag,
  output logic [ADDR_W-1:0]    err_rd,
  output logic [DATA_W-1:0]    err_value,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int unsigned NREGS = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [NREGS];
  logic              pend_valid;
  logic              pend_we;
  logic [ADDR_W-1:0] pend_rd;
  logic [DATA_W-1:0] pend_data;

  logic accept;
  logic err_accept;
  logic pend_we_d;
  logic pend_hit_rs;
  logic pend_hit_rt;

  // wb_ready depends only on the registered error flag
  assign wb_ready   = !(HALT_ON_ERR && err_flag);
  assign accept     = wb_valid && wb_ready;
  assign err_accept = accept && wb_is_false;
  assign pend_we_d  = wb_reg_write && !wb_is_false && (wb_rd != '0);

  // Single-entry staging register between the ALU and the array
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid <= 1'b0;
      pend_we    <= 1'b0;
      pend_rd    <= '0;
      pend_data  <= '0;
    end else if (accept) begin
      pend_valid <= 1'b1;
      pend_we    <= pend_we_d;
      pend_rd    <= wb_rd;
      pend_data  <= wb_result;
    end else begin
      pend_valid <= 1'b0;
    end
  end

  // Register array; pend_we already excludes index 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (pend_valid && pend_we) begin
      regs[pend_rd] <= pend_data;
    end
  end

  assign pend_hit_rs = pend_valid && pend_we && (rs_addr == pend_rd);
  assign pend_hit_rt = pend_valid && pend_we && (rt_addr == pend_rd);

  // Read ports: x0 is hardwired zero, staged write takes priority over the array
  always_comb begin
    rs_data = regs[rs_addr];
    if (rs_addr == '0) begin
      rs_data = '0;
    end else if (pend_hit_rs) begin
      rs_data = pend_data;
    end
  end

  always_comb begin
    rt_data = regs[rt_addr];
    if (rt_addr == '0) begin
      rt_data = '0;
    end else if (pend_hit_rt) begin
      rt_data = pend_data;
    end
  end

  // Error capture: an errored accept beats a simultaneous clear and recaptures
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_flag  <= 1'b0;
      err_rd    <= '0;
      err_value <= '0;
      err_count <= '0;
    end else if (err_accept) begin
      err_flag <= 1'b1;
      if (!err_flag || err_clear) begin
        err_rd    <= wb_rd;
        err_value <= wb_result;
      end
      if (err_count != '1) begin
        err_count <= err_count + ERR_CNT_W'(1);
      end
    end else if (err_clear) begin
      err_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_writeback_regfile.sv
// Bench for alu_writeback_regfile: directed and random beats against an architectural model
// (latest accepted write per register); one instance per HALT_ON_ERR setting.
module tb_alu_writeback_regfile;

  logic        clk;
  logic        rst_n;
  logic        wb_valid;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_result;
  logic        wb_is_false;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic        err_clear;

  logic        ready0, ready1;
  logic [31:0] rs0, rs1, rt0, rt1;
  logic        flag0, flag1;
  logic [4:0]  erd0, erd1;
  logic [31:0] ev0, ev1;
  logic [7:0]  ecnt0, ecnt1;

  alu_writeback_regfile #(.DATA_W(32), .ADDR_W(5), .ERR_CNT_W(8), .HALT_ON_ERR(1'b1)) u_halt (
    .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .wb_ready(ready0),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
    .wb_is_false(wb_is_false), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs0), .rt_data(rt0), .err_clear(err_clear), .err_flag(flag0),
    .err_rd(erd0), .err_value(ev0), .err_count(ecnt0)
  );

  alu_writeback_regfile #(.DATA_W(32), .ADDR_W(5), .ERR_CNT_W(8), .HALT_ON_ERR(1'b0)) u_nohalt (
    .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .wb_ready(ready1),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
    .wb_is_false(wb_is_false), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs1), .rt_data(rt1), .err_clear(err_clear), .err_flag(flag1),
    .err_rd(erd1), .err_value(ev1), .err_count(ecnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit sel   = 1'b0;   // 0: checking u_halt, 1: checking u_nohalt

  // Architectural model of the selected instance
  logic [31:0] mreg [32];
  bit          mflag;
  logic [4:0]  merd;
  logic [31:0] merv;
  int          mcnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mreg[i] = 32'h0;
    mflag = 1'b0;
    merd  = 5'd0;
    merv  = 32'h0;
    mcnt  = 0;
  endtask

  function automatic bit model_ready();
    return !(sel == 1'b0 && mflag);
  endfunction

  // Apply the effect of the upcoming rising edge to the model
  task automatic model_edge();
    bit acc;
    acc = wb_valid && model_ready();
    if (acc && wb_is_false) begin
      if (!mflag || err_clear) begin
        merd = wb_rd;
        merv = wb_result;
      end
      mflag = 1'b1;
      if (mcnt < 255) mcnt++;
    end else begin
      if (err_clear) mflag = 1'b0;
      if (acc && wb_reg_write && wb_rd != 5'd0) mreg[wb_rd] = wb_result;
    end
  endtask

  task automatic check_all();
    chk("wb_ready",  32'(sel ? ready1 : ready0), 32'(model_ready()));
    chk("err_flag",  32'(sel ? flag1 : flag0),   32'(mflag));
    chk("err_rd",    32'(sel ? erd1 : erd0),     32'(merd));
    chk("err_value", sel ? ev1 : ev0,            merv);
    chk("err_count", 32'(sel ? ecnt1 : ecnt0),   32'(mcnt));
    chk("rs_data",   sel ? rs1 : rs0,            (rs_addr == 5'd0) ? 32'h0 : mreg[rs_addr]);
    chk("rt_data",   sel ? rt1 : rt0,            (rt_addr == 5'd0) ? 32'h0 : mreg[rt_addr]);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic beat(input bit v, input bit we, input logic [4:0] rd, input logic [31:0] res,
                      input bit f, input bit clr);
    wb_valid = v; wb_reg_write = we; wb_rd = rd; wb_result = res; wb_is_false = f; err_clear = clr;
    tick();
    wb_valid = 1'b0; wb_is_false = 1'b0; err_clear = 1'b0;
  endtask

  task automatic random_beat();
    wb_valid     = ($urandom_range(0, 3) != 0);
    wb_reg_write = ($urandom_range(0, 4) != 0);
    wb_rd        = 5'($urandom);
    wb_result    = $urandom;
    wb_is_false  = ($urandom_range(0, 7) == 0);
    err_clear    = ($urandom_range(0, 5) == 0);
    rs_addr      = 5'($urandom);
    rt_addr      = ($urandom_range(0, 1) == 0) ? wb_rd : 5'($urandom);
    tick();
  endtask

  task automatic hard_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    wb_valid = 1'b0; wb_is_false = 1'b0; err_clear = 1'b0;
    model_reset();
    #10;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    wb_valid = 1'b0; wb_reg_write = 1'b0; wb_rd = 5'd0; wb_result = 32'h0;
    wb_is_false = 1'b0; rs_addr = 5'd0; rt_addr = 5'd0; err_clear = 1'b0;
    model_reset();
    #23;
    rst_n = 1'b1;

    // 1: reset state, every address reads zero
    for (int i = 0; i < 16; i++) begin
      rs_addr = 5'(2 * i);
      rt_addr = 5'(2 * i + 1);
      tick();
    end

    // 2: bypass immediately after accept, then array value
    rs_addr = 5'd5;
    beat(1'b1, 1'b1, 5'd5, 32'h1234_5678, 1'b0, 1'b0);
    chk("bypass_rd5", rs0, 32'h1234_5678);
    tick();
    tick();
    chk("array_rd5", rs0, 32'h1234_5678);

    // 3: back-to-back beats to the same register, then a write to x0
    rt_addr = 5'd3;
    beat(1'b1, 1'b1, 5'd3, 32'h1, 1'b0, 1'b0);
    chk("b2b_first", rt0, 32'h1);
    beat(1'b1, 1'b1, 5'd3, 32'h2, 1'b0, 1'b0);
    chk("b2b_second", rt0, 32'h2);
    tick();
    chk("b2b_hold", rt0, 32'h2);
    rs_addr = 5'd0;
    beat(1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    tick();
    chk("x0_zero", rs0, 32'h0);

    // 4: errored beat is dropped, captured, and halts the block
    rs_addr = 5'd7;
    beat(1'b1, 1'b1, 5'd7, 32'h8000_0000, 1'b1, 1'b0);
    chk("err_no_write", rs0, 32'h0);
    chk("halt_ready", 32'(ready0), 32'h0);
    // a beat offered while halted is neither accepted nor bypassed
    rs_addr = 5'd4;
    beat(1'b1, 1'b1, 5'd4, 32'hDEAD_BEEF, 1'b0, 1'b0);
    tick();

    // 5: clear releases the halt; errored beat coincident with clear recaptures
    beat(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
    chk("clear_erd_kept", 32'(erd0), 32'd7);
    beat(1'b1, 1'b1, 5'd9, 32'h0000_0099, 1'b1, 1'b1);
    chk("recapture_rd9", 32'(erd0), 32'd9);
    chk("count_two", 32'(ecnt0), 32'd2);
    beat(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);

    // random traffic on the halting instance
    for (int n = 0; n < 400; n++) random_beat();
    wb_valid = 1'b0; err_clear = 1'b0;

    // 6: non-halting instance, saturating error counter
    sel = 1'b1;
    hard_reset();
    rs_addr = 5'd0; rt_addr = 5'd0;
    beat(1'b1, 1'b1, 5'd11, 32'hCAFE_0001, 1'b1, 1'b0);
    for (int n = 1; n < 300; n++) begin
      beat(1'b1, 1'b1, 5'($urandom), $urandom, 1'b1, 1'b0);
    end
    chk("sat_count", 32'(ecnt1), 32'd255);
    chk("sat_first_rd", 32'(erd1), 32'd11);
    chk("sat_ready", 32'(ready1), 32'h1);

    // random traffic then an asynchronous reset mid-stream
    for (int n = 0; n < 150; n++) random_beat();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    wb_valid = 1'b0; wb_is_false = 1'b0; err_clear = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("rst_count", 32'(ecnt1), 32'h0);
    #10;
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rs_addr = 5'(2 * i);
      rt_addr = 5'(2 * i + 1);
      tick();
    end
    for (int n = 0; n < 200; n++) random_beat();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
